// File: rtl/alu_pattern_sequencer_if.sv
// Signal bundle between the pattern sequencer (master) and the 2-bit alu under test (slave).
interface alu_pattern_sequencer_if;
  logic [1:0] ain;
  logic [1:0] bin;
  logic       sel;
  logic [1:0] zout;

  modport master (output ain, output bin, output sel, input zout);
  modport slave  (input ain, input bin, input sel, output zout);
endinterface

// File: rtl/alu_pattern_sequencer.sv
// On-chip capture/measure engine: applies stored vectors to the alu, waits a settle
// window, strobes zout against masked expectations and records pass/fail statistics.
module alu_pattern_sequencer #(
  parameter int NPAT       = 16,
  parameter int AW         = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [AW:0]             num_pat,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [4:0]              wr_pi,
  input  logic [1:0]              wr_xpct,
  input  logic [1:0]              wr_mask,
  alu_pattern_sequencer_if.master alu,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [AW:0]             fail_cnt,
  output logic [AW-1:0]           first_fail_idx,
  output logic                    first_fail_vld
);

  localparam int          CW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [AW:0] NPAT_W = (AW+1)'(NPAT);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, STROBE, DONE} state_t;

  state_t          state, next_state;
  logic [8:0]      mem [NPAT];
  logic [AW-1:0]   idx;
  logic [CW-1:0]   settle_cnt;
  logic [AW:0]     run_len;
  logic [AW:0]     num_eff;
  logic [1:0]      ain_q, bin_q;
  logic            sel_q;
  logic [8:0]      rd;
  logic            last;
  logic            mismatch;
  logic            aborting;

  // Entry layout: {ain[1:0], bin[1:0], sel, xpct[1:0], mask[1:0]}
  assign rd       = mem[idx];
  assign num_eff  = (num_pat > NPAT_W) ? NPAT_W : num_pat;
  assign last     = ({1'b0, idx} == (run_len - (AW+1)'(1)));
  assign mismatch = |((alu.zout ^ rd[3:2]) & rd[1:0]);
  assign aborting = abort && (state != IDLE);
  assign busy     = (state == APPLY) || (state == SETTLE) || (state == STROBE);

  assign alu.ain = ain_q;
  assign alu.bin = bin_q;
  assign alu.sel = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (num_eff != '0) ? APPLY : DONE;
      APPLY:   next_state = SETTLE;
      SETTLE:  if (settle_cnt == '0) next_state = STROBE;
      STROBE:  next_state = last ? DONE : APPLY;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (aborting) next_state = IDLE;
  end

  // Abort wins over every state action; statistics from the aborted run are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPAT; i++) mem[i] <= '0;
      idx            <= '0;
      settle_cnt     <= '0;
      run_len        <= '0;
      ain_q          <= '0;
      bin_q          <= '0;
      sel_q          <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en && state == IDLE) mem[wr_addr] <= {wr_pi, wr_xpct, wr_mask};
      if (aborting) begin
        ain_q <= '0;
        bin_q <= '0;
        sel_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              fail_cnt       <= '0;
              first_fail_vld <= 1'b0;
              pass           <= 1'b0;
              idx            <= '0;
              run_len        <= num_eff;
            end
          end
          APPLY: begin
            ain_q      <= rd[8:7];
            bin_q      <= rd[6:5];
            sel_q      <= rd[4];
            settle_cnt <= CW'(SETTLE_CYC - 1);
          end
          SETTLE: begin
            if (settle_cnt != '0) settle_cnt <= settle_cnt - CW'(1);
          end
          STROBE: begin
            if (mismatch) begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + (AW+1)'(1);
              if (!first_fail_vld) begin
                first_fail_idx <= idx;
                first_fail_vld <= 1'b1;
              end
            end
            if (!last) idx <= idx + AW'(1);
          end
          DONE: begin
            done  <= 1'b1;
            pass  <= (fail_cnt == '0);
            ain_q <= '0;
            bin_q <= '0;
            sel_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_pattern_sequencer.sv
// Randomised scoreboard bench for alu_pattern_sequencer driving a behavioural alu
// (sel=1: a&b, sel=0: a+b mod 4) with selectable faults on zout.
module tb_alu_pattern_sequencer;
  localparam int NPAT   = 16;
  localparam int AW     = 4;
  localparam int SETTLE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW:0]   num_pat = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [4:0]    wr_pi = '0;
  logic [1:0]    wr_xpct = '0;
  logic [1:0]    wr_mask = '0;
  logic          busy, done, pass, first_fail_vld;
  logic [AW:0]   fail_cnt;
  logic [AW-1:0] first_fail_idx;

  alu_pattern_sequencer_if alu_bus();

  alu_pattern_sequencer #(.NPAT(NPAT), .AW(AW), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_pat(num_pat),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_pi(wr_pi), .wr_xpct(wr_xpct), .wr_mask(wr_mask),
    .alu(alu_bus), .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld)
  );

  always #5 clk = ~clk;

  int          faultMode = 0;
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // mode 1: zout[1] stuck-at-0, 2: zout[1] unknown, 3: zout forced to 11
  function automatic logic [1:0] aluOut(logic [1:0] a, logic [1:0] b, logic s, int mode);
    logic [1:0] z;
    z = s ? (a & b) : (a + b);
    case (mode)
      1: z[1] = 1'b0;
      2: z[1] = 1'bx;
      3: z = 2'b11;
      default: ;
    endcase
    return z;
  endfunction

  assign alu_bus.zout = aluOut(alu_bus.ain, alu_bus.bin, alu_bus.sel, faultMode);

  logic [4:0] mPi [NPAT];
  logic [1:0] mX  [NPAT];
  logic [1:0] mM  [NPAT];

  typedef struct {
    int unsigned t0;
    int unsigned lat;
    logic [AW:0] cnt;
    logic        vld;
    logic [AW-1:0] idx;
    logic        pss;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  exp_t runE;

  logic [8:0] golden [12] = '{
    9'b11101_10_11, 9'b01101_00_11, 9'b01111_01_11, 9'b10011_00_11,
    9'b11010_00_11, 9'b01110_00_11, 9'b01000_01_11, 9'b01010_10_11,
    9'b11100_01_11, 9'b01100_11_11, 9'b11110_10_11, 9'b10110_01_01
  };

  function automatic exp_t model(int np, int mode);
    exp_t r;
    int n;
    int c;
    logic [1:0] z;
    r.t0 = 0; r.vld = 1'b0; r.idx = '0; c = 0;
    n = (np > NPAT) ? NPAT : np;
    for (int i = 0; i < n; i++) begin
      z = aluOut(mPi[i][4:3], mPi[i][2:1], mPi[i][0], mode);
      if (((z ^ mX[i]) & mM[i]) != 2'b00) begin
        if (c < (2**(AW+1)) - 1) c++;
        if (!r.vld) begin
          r.vld = 1'b1;
          r.idx = AW'(i);
        end
      end
    end
    r.cnt = (AW+1)'(c);
    r.pss = (c == 0);
    r.lat = n * (SETTLE + 2) + 1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic writeEntry(input int addr, input logic [4:0] pi, input logic [1:0] x, input logic [1:0] m);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_pi = pi; wr_xpct = x; wr_mask = m;
    mPi[addr] = pi; mX[addr] = x; mM[addr] = m;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // kind 0: complete run, 1: abort in SETTLE of pattern 3, 2: async reset in STROBE of pattern 0
  task automatic applyStimulus(input int np, input int mode, input int kind, input bit sameWr, input bit busyPoke);
    int n;
    int w;
    int a;
    exp_t part;
    faultMode = mode;
    n = (np > NPAT) ? NPAT : np;
    @(negedge clk);
    if (sameWr) begin
      a = $urandom_range(0, NPAT-1);
      wr_en = 1'b1; wr_addr = AW'(a);
      wr_pi = 5'($urandom_range(0, 31)); wr_xpct = 2'($urandom_range(0, 3)); wr_mask = 2'($urandom_range(0, 3));
      mPi[a] = wr_pi; mX[a] = wr_xpct; mM[a] = wr_mask;
    end
    start = 1'b1;
    num_pat = (AW+1)'(np);
    runE = model(np, mode);
    @(posedge clk);
    #1;
    runE.t0 = cyc;
    if (kind == 0) sbq.push_back(runE);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    if (busyPoke && n > 0) begin
      @(negedge clk);
      start = 1'b1;
      wr_en = 1'b1; wr_addr = AW'($urandom_range(0, NPAT-1));
      wr_pi = 5'($urandom_range(0, 31)); wr_xpct = 2'($urandom_range(0, 3)); wr_mask = 2'b11;
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
    end
    if (kind == 1) begin
      while (cyc < runE.t0 + 20) @(negedge clk);
      checkOutput("busy_before_abort", 32'(busy), 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      part = model(3, mode);
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_alu_bus", 32'({alu_bus.ain, alu_bus.bin, alu_bus.sel}), 0);
      checkOutput("abort_pass", 32'(pass), 0);
      checkOutput("abort_fail_cnt", 32'(fail_cnt), 32'(part.cnt));
      @(negedge clk);
      abort = 1'b0;
      repeat (8) @(negedge clk);
    end else if (kind == 2) begin
      while (cyc < runE.t0 + 5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs",
                  32'({alu_bus.ain, alu_bus.bin, alu_bus.sel, busy, done, pass, fail_cnt, first_fail_idx, first_fail_vld}), 0);
      for (int i = 0; i < NPAT; i++) begin
        mPi[i] = '0; mX[i] = '0; mM[i] = '0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end else begin
      w = 0;
      while (sbq.size() != 0 && w < 500) begin
        @(negedge clk);
        w++;
      end
      if (sbq.size() != 0) begin
        checkOutput("done_timeout", 32'(sbq.size()), 0);
        sbq.delete();
      end
    end
  endtask

  // Monitor: every done pulse retires the oldest expected run result.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && done) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious_done", 32'(done), 0);
        end else begin
          monE = sbq.pop_front();
          checkOutput("done_latency", cyc - monE.t0, monE.lat);
          checkOutput("fail_cnt", 32'(fail_cnt), 32'(monE.cnt));
          checkOutput("first_fail_vld", 32'(first_fail_vld), 32'(monE.vld));
          if (monE.vld) checkOutput("first_fail_idx", 32'(first_fail_idx), 32'(monE.idx));
          checkOutput("pass", 32'(pass), 32'(monE.pss));
          checkOutput("done_alu_bus", 32'({alu_bus.ain, alu_bus.bin, alu_bus.sel}), 0);
          checkOutput("done_busy", 32'(busy), 0);
        end
      end
    end
  end

  initial begin
    logic [4:0] pi;
    logic [1:0] z;
    for (int i = 0; i < NPAT; i++) begin
      mPi[i] = '0; mX[i] = '0; mM[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({alu_bus.ain, alu_bus.bin, alu_bus.sel, busy, done, pass, fail_cnt, first_fail_idx, first_fail_vld}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] golden run and zout[1] stuck-at-0 rerun");
    for (int i = 0; i < 12; i++) writeEntry(i, golden[i][8:4], golden[i][3:2], golden[i][1:0]);
    applyStimulus(12, 0, 0, 1'b0, 1'b0);
    applyStimulus(12, 1, 0, 1'b0, 1'b0);

    $display("[TB] abort then clean rerun");
    applyStimulus(12, 1, 1, 1'b0, 1'b0);
    applyStimulus(12, 0, 0, 1'b0, 1'b0);

    $display("[TB] empty run");
    applyStimulus(0, 1, 0, 1'b0, 1'b0);

    $display("[TB] all-fail run with num_pat clamp");
    for (int i = 0; i < NPAT; i++) begin
      pi = 5'($urandom_range(0, 31));
      z = aluOut(pi[4:3], pi[2:1], pi[0], 0);
      writeEntry(i, pi, z ^ 2'b01, 2'b11);
    end
    applyStimulus(17, 0, 0, 1'b0, 1'b0);

    $display("[TB] masking");
    writeEntry(0, golden[11][8:4], golden[11][3:2], golden[11][1:0]);
    applyStimulus(1, 2, 0, 1'b0, 1'b0);
    writeEntry(0, golden[11][8:4], 2'b01, 2'b11);
    applyStimulus(1, 3, 0, 1'b0, 1'b0);

    $display("[TB] randomised runs");
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        writeEntry($urandom_range(0, NPAT-1), 5'($urandom_range(0, 31)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      applyStimulus($urandom_range(0, 20), $urandom_range(0, 1), 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] async reset mid-strobe, memory cleared");
    for (int i = 0; i < 12; i++) writeEntry(i, golden[i][8:4], golden[i][3:2], golden[i][1:0]);
    applyStimulus(12, 0, 2, 1'b0, 1'b0);
    applyStimulus(16, 3, 0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
